alu_cmd_responder: RTL and testbench
====================================

# alu_cmd_responder

Registered command-execution wrapper for the 4-bit ALU opcode set. It accepts operand/opcode requests over a valid/ready channel, computes result and zero flag, and returns tagged responses through a small response FIFO with its own valid/ready channel. A mutant-select input injects one of seven fixed faults into the computation. This lets the test initiator measure mutation detection against real handshaked hardware instead of a purely combinational unit.

## Interface
- WIDTH, 4: operand/result width.
- DEPTH, 2: response FIFO entries; must be ≥2 and a power of two.
- TAG_W, 2: request tag width, echoed on the response.
- CNT_W, 16: accepted-op counter width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_a, req_b  in  WIDTH  operands.
- req_opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 EQ, 110 LT, 111 NOP.
- req_tag  in  TAG_W  opaque tag.
- mutant_sel  in  3  fault select; 0 selects no fault.
- rsp_valid  out  1  response at FIFO head.
- rsp_ready  in  1  consumer takes response.
- rsp_result  out  WIDTH  result of head entry.
- rsp_zero  out  1  zero flag of head entry.
- rsp_tag  out  TAG_W  tag of head entry.
- op_count  out  CNT_W  number of accepted requests.

## Operation
- Accept: fires when req_valid && req_ready. Result, zero flag and tag are pushed into the FIFO on that edge.
- req_ready = !rst && (FIFO occupancy < DEPTH). There is no pass-through when the FIFO is full: a pop in the same cycle does not raise req_ready.
- Arithmetic: ADD and SUB are modulo 2^WIDTH; carry and borrow are discarded.
- EQ yields 1 if A==B, else 0. LT is unsigned A<B, yielding 1 or 0. Both results are zero-extended to WIDTH. NOP yields 0.
- zero = (final result == 0), computed after any mutation is applied.
- mutant_sel is sampled at accept and affects only that entry:
  - 1: ADD computes A−B.
  - 2: AND computes A|B.
  - 3: zero flag inverted.
  - 4: LT computes A≤B.
  - 5: EQ result inverted (1↔0).
  - 6: result bit 0 forced to 0.
  - 7: NOP returns all-ones.
- FIFO: head drives rsp_*. A pop occurs when rsp_valid && rsp_ready. Entries leave in accept order.
- FIFO boundaries:
  - Simultaneous push and pop: occupancy unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- rsp_* data is held stable while rsp_valid && !rsp_ready.
- op_count increments once per accept and wraps from 2^CNT_W−1 to 0.
- Reset:
  - Asynchronously clears the FIFO (occupancy 0, pointers 0).
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_tag=0, op_count=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards all queued responses. Any request presented in the reset cycle is dropped.

## Timing
- Accept-to-response latency is 1 cycle: an entry accepted at edge N is visible on rsp_* after edge N, provided the FIFO was empty.
- Throughput is 1 op/cycle when rsp_ready is held high.
- With rsp_ready low, DEPTH accepts fill the FIFO. req_ready drops after the DEPTH-th accept edge and rises the cycle after the first pop.
- req_ready is high in the first cycle after rst deasserts.
- rsp_valid is registered state (occupancy ≠ 0). There is no combinational path from req_* to rsp_*.

## Test plan
- Opcode sweep, A=3, B=2, mutant_sel=0, one request per opcode 000→111 with tags 0..3 repeating, rsp_ready=1 → results 5, 1, 2, 3, 1, 0, 0, 0; zero flags 0, 0, 0, 0, 0, 1, 1, 1; each response appears 1 cycle after accept with the matching tag.
- Wrap and compare edges: A=15, B=1 ADD → 0, zero=1. A=0, B=1 SUB → 15, zero=0. A=B=7 EQ → 1, zero=0. A=1, B=2 LT → 1.
- Back-pressure with rsp_ready=0: three back-to-back requests → only two accepted; req_ready low after the 2nd accept; raising rsp_ready pops in order, and req_ready returns the cycle after the first pop.
- Mutants with A=3, B=2:
  - sel=1 ADD → 1.
  - sel=2 AND → 3.
  - sel=3 ADD → zero=1.
  - sel=4 with A=B=2 LT → 1.
  - sel=5 EQ → 1.
  - sel=6 ADD → 4.
  - sel=7 NOP → 15, zero=0.
- Reset mid-stream: two queued responses, then assert rst asynchronously between edges → rsp_valid, req_ready and op_count go to 0 immediately; after release the next request gets latency 1 and op_count=1.

Source files
------------

// File: rtl/alu_cmd_responder.sv
// Handshaked ALU command executor: computes result/zero for each accepted request
// (with optional injected fault) and returns tagged responses through a small FIFO.
module alu_cmd_responder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_opcode,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [2:0]       mutant_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_EQ  = 3'b101,
        OP_LT  = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             push_c;
    logic             pop_c;
    logic [WIDTH-1:0] result_c;
    logic             zero_c;
    entry_t           entry_c;

    // Ready only reflects stored occupancy; a same-cycle pop does not free a slot.
    assign req_ready = !rst && (occ < OCC_W'(DEPTH));
    assign push_c    = req_valid && req_ready;
    assign pop_c     = rsp_valid && rsp_ready;

    assign rsp_valid  = (occ != '0);
    assign rsp_result = mem[rd_ptr].result;
    assign rsp_zero   = mem[rd_ptr].zero;
    assign rsp_tag    = mem[rd_ptr].tag;

    // Opcode evaluation with the selected fault folded in before the zero flag.
    always_comb begin
        result_c = '0;
        zero_c   = 1'b0;
        unique case (opcode_e'(req_opcode))
            OP_ADD:  result_c = (mutant_sel == 3'd1) ? req_a - req_b : req_a + req_b;
            OP_SUB:  result_c = req_a - req_b;
            OP_AND:  result_c = (mutant_sel == 3'd2) ? (req_a | req_b) : (req_a & req_b);
            OP_OR:   result_c = req_a | req_b;
            OP_XOR:  result_c = req_a ^ req_b;
            OP_EQ:   result_c = WIDTH'((req_a == req_b) ^ (mutant_sel == 3'd5));
            OP_LT:   result_c = (mutant_sel == 3'd4) ? WIDTH'(req_a <= req_b)
                                                     : WIDTH'(req_a < req_b);
            OP_NOP:  result_c = (mutant_sel == 3'd7) ? '1 : '0;
            default: result_c = '0;
        endcase
        if (mutant_sel == 3'd6) begin
            result_c[0] = 1'b0;
        end
        zero_c = (result_c == '0) ^ (mutant_sel == 3'd3);
    end

    always_comb begin
        entry_c        = '0;
        entry_c.result = result_c;
        entry_c.zero   = zero_c;
        entry_c.tag    = req_tag;
    end

    // Response FIFO storage, pointers, occupancy and accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem      <= '{default: '0};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            op_count <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= entry_c;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                op_count    <= op_count + CNT_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_responder.sv
// Bench for alu_cmd_responder: directed vector table, back-pressure and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_alu_cmd_responder;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_opcode;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       mutant_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic [CNT_W-1:0] op_count;

    int n_vec;
    int n_err;

    alu_cmd_responder #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_tag(req_tag),
        .mutant_sel(mutant_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int op;
        int mut;
        int res;
        int zero;
    } vec_t;

    typedef struct {
        int res;
        int zero;
        int tag;
    } rsp_t;

    vec_t vt[19];
    rsp_t mq[$];
    int   mcount;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int a, input int b, input int op, input int mut,
                                input int res, input int zero);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.mut = mut; v.res = res; v.zero = zero;
        return v;
    endfunction

    // Reference: opcode rules in plain integer arithmetic, then the fault list.
    function automatic rsp_t model(input int a, input int b, input int op, input int mut,
                                   input int tag);
        rsp_t r;
        int   v;
        int   m;
        m = (1 << WIDTH) - 1;
        case (op)
            0: v = (mut == 1) ? a - b : a + b;
            1: v = a - b;
            2: v = (mut == 2) ? (a | b) : (a & b);
            3: v = a | b;
            4: v = a ^ b;
            5: begin
                v = (a == b) ? 1 : 0;
                if (mut == 5) v = 1 - v;
            end
            6: v = (mut == 4) ? ((a <= b) ? 1 : 0) : ((a < b) ? 1 : 0);
            default: v = (mut == 7) ? m : 0;
        endcase
        v = v & m;
        if (mut == 6) v = v & ~1;
        r.res  = v;
        r.zero = (v == 0) ? 1 : 0;
        if (mut == 3) r.zero = 1 - r.zero;
        r.tag  = tag;
        return r;
    endfunction

    task automatic drive(input int a, input int b, input int op, input int mut, input int tag);
        req_valid  = 1'b1;
        req_a      = WIDTH'(a);
        req_b      = WIDTH'(b);
        req_opcode = 3'(op);
        mutant_sel = 3'(mut);
        req_tag    = TAG_W'(tag);
    endtask

    initial begin
        int   sweep_res[8];
        int   sweep_z[8];
        int   base;
        rsp_t e;
        bit   exp_ready;

        n_vec = 0;
        n_err = 0;
        sweep_res = '{5, 1, 2, 3, 1, 0, 0, 0};
        sweep_z   = '{0, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) vt[i] = mk(3, 2, i, 0, sweep_res[i], sweep_z[i]);
        vt[8]  = mk(15, 1, 0, 0, 0, 1);
        vt[9]  = mk(0, 1, 1, 0, 15, 0);
        vt[10] = mk(7, 7, 5, 0, 1, 0);
        vt[11] = mk(1, 2, 6, 0, 1, 0);
        vt[12] = mk(3, 2, 0, 1, 1, 0);
        vt[13] = mk(3, 2, 2, 2, 3, 0);
        vt[14] = mk(3, 2, 0, 3, 5, 1);
        vt[15] = mk(2, 2, 6, 4, 1, 0);
        vt[16] = mk(3, 2, 5, 5, 1, 0);
        vt[17] = mk(3, 2, 0, 6, 4, 0);
        vt[18] = mk(3, 2, 7, 7, 15, 0);

        rst = 1'b1;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; req_tag = '0;
        mutant_sel = '0; rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_op_count", 32'(op_count), 0);
        chk("reset_rsp_result", 32'(rsp_result), 0);
        chk("reset_rsp_tag", 32'(rsp_tag), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 1);

        // Back-to-back table: each response must be at the head one cycle after accept.
        rsp_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].op, vt[i].mut, i % 4);
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 1);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 1);
            chk($sformatf("vec%0d_result", i), 32'(rsp_result), 32'(vt[i].res));
            chk($sformatf("vec%0d_zero", i), 32'(rsp_zero), 32'(vt[i].zero));
            chk($sformatf("vec%0d_tag", i), 32'(rsp_tag), 32'(i % 4));
        end
        req_valid = 1'b0;
        chk("table_op_count", 32'(op_count), 19);
        tick();
        chk("drained", 32'(rsp_valid), 0);

        // Back-pressure: three requests offered, only DEPTH accepted.
        rsp_ready = 1'b0;
        base = 19;
        drive(1, 1, 0, 0, 1);
        tick();
        drive(5, 1, 1, 0, 2);
        chk("bp_ready_2nd", 32'(req_ready), 1);
        tick();
        chk("bp_ready_low", 32'(req_ready), 0);
        chk("bp_head_1", 32'(rsp_result), 2);
        drive(9, 9, 4, 0, 3);
        tick();
        chk("bp_third_dropped", 32'(op_count), 32'(base + 2));
        chk("bp_head_held", 32'(rsp_tag), 1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("bp_no_passthrough", 32'(req_ready), 0);
        tick();
        chk("bp_ready_back", 32'(req_ready), 1);
        chk("bp_head_2", 32'(rsp_result), 4);
        chk("bp_head_2_tag", 32'(rsp_tag), 2);
        tick();
        chk("bp_empty", 32'(rsp_valid), 0);

        // Asynchronous reset with two responses queued.
        rsp_ready = 1'b0;
        drive(1, 0, 3, 0, 0);
        tick();
        tick();
        req_valid = 1'b0;
        chk("rm_queued", 32'(rsp_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("rm_rsp_valid", 32'(rsp_valid), 0);
        chk("rm_req_ready", 32'(req_ready), 0);
        chk("rm_op_count", 32'(op_count), 0);
        drive(2, 2, 0, 0, 1);
        tick();
        chk("rm_dropped", 32'(op_count), 0);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rm_ready_release", 32'(req_ready), 1);
        drive(1, 1, 0, 0, 3);
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rm_latency1", 32'(rsp_valid), 1);
        chk("rm_result", 32'(rsp_result), 2);
        chk("rm_op_count1", 32'(op_count), 1);

        // Random traffic against the queue model, starting from a clean reset.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        mq.delete();
        mcount = 0;
        for (int c = 0; c < 400; c++) begin
            exp_ready = (mq.size() < DEPTH);
            chk("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(mq.size() != 0));
            chk("rnd_op_count", 32'(op_count), 32'(mcount));
            if (mq.size() != 0) begin
                chk("rnd_result", 32'(rsp_result), 32'(mq[0].res));
                chk("rnd_zero", 32'(rsp_zero), 32'(mq[0].zero));
                chk("rnd_tag", 32'(rsp_tag), 32'(mq[0].tag));
            end
            drive(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(7)),
                  int'($urandom_range(7)), int'($urandom_range(3)));
            req_valid = ($urandom_range(3) != 0);
            rsp_ready = ($urandom_range(2) != 0);
            if (rsp_ready && mq.size() != 0) void'(mq.pop_front());
            if (req_valid && exp_ready) begin
                e = model(int'(req_a), int'(req_b), int'(req_opcode), int'(mutant_sel),
                          int'(req_tag));
                mq.push_back(e);
                mcount = (mcount + 1) % (1 << CNT_W);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
